// File: rtl/uart_rx.sv
// Oversampling UART receiver: 2-flop RX synchronizer, mid-bit sampling, valid/ready output stage.
// Define UART_RX_PARITY_EN to add an even-parity bit after the data bits and the PAR_ERR pulse output.
`timescale 1ns/1ps

module uart_rx #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   input  logic                 BCLK,
   input  logic                 RX,
   input  logic                 READY,
   output logic [DATA_BITS-1:0] DATA,
   output logic                 VALID,
   output logic                 FRAME_ERR,
   output logic                 OVERRUN,
`ifdef UART_RX_PARITY_EN
   output logic                 PAR_ERR,
`endif
   output logic [2:0]           STATE_DBG
);

   localparam int TICK_W = $clog2(OVERSAMPLE);
   localparam int BIT_W  = $clog2(DATA_BITS + 1);
   localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_STOP   = 3'd3,
`ifdef UART_RX_PARITY_EN
      S_BREAK  = 3'd4,
      S_PARITY = 3'd5
`else
      S_BREAK  = 3'd4
`endif
   } state_t;

   state_t               state;
   logic                 rx_meta;
   logic                 rxs;
   logic [TICK_W-1:0]    tick_cnt;
   logic [BIT_W-1:0]     bit_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 word_done;
`ifdef UART_RX_PARITY_EN
   logic                 par_bad;
`endif

   assign STATE_DBG = state;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         rx_meta <= 1'b1;
         rxs     <= 1'b1;
      end else begin
         rx_meta <= RX;
         rxs     <= rx_meta;
      end
   end

   // After the start bit is confirmed at mid-bit, every later sample lands a full bit period apart.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state     <= S_IDLE;
         tick_cnt  <= '0;
         bit_cnt   <= '0;
         shreg     <= '0;
         FRAME_ERR <= 1'b0;
`ifdef UART_RX_PARITY_EN
         PAR_ERR   <= 1'b0;
         par_bad   <= 1'b0;
`endif
      end else begin
         FRAME_ERR <= 1'b0;
`ifdef UART_RX_PARITY_EN
         PAR_ERR   <= 1'b0;
`endif
         if (BCLK) begin
            case (state)
               S_IDLE: begin
                  if (!rxs) begin
                     state    <= S_START;
                     tick_cnt <= '0;
                  end
               end
               S_START: begin
                  if (tick_cnt == TICK_MID) begin
                     tick_cnt <= '0;
                     bit_cnt  <= '0;
                     state    <= rxs ? S_IDLE : S_DATA;
`ifdef UART_RX_PARITY_EN
                     par_bad  <= 1'b0;
`endif
                  end else begin
                     tick_cnt <= tick_cnt + TICK_W'(1);
                  end
               end
               S_DATA: begin
                  if (tick_cnt == TICK_LAST) begin
                     tick_cnt <= '0;
                     shreg    <= {rxs, shreg[DATA_BITS-1:1]};
                     if (bit_cnt == BIT_LAST) begin
                        bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                        state   <= S_PARITY;
`else
                        state   <= S_STOP;
`endif
                     end else begin
                        bit_cnt <= bit_cnt + BIT_W'(1);
                     end
                  end else begin
                     tick_cnt <= tick_cnt + TICK_W'(1);
                  end
               end
`ifdef UART_RX_PARITY_EN
               S_PARITY: begin
                  if (tick_cnt == TICK_LAST) begin
                     tick_cnt <= '0;
                     state    <= S_STOP;
                     // Even parity: data bits plus parity bit carry an even number of ones.
                     if (rxs != ^shreg) begin
                        PAR_ERR <= 1'b1;
                        par_bad <= 1'b1;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + TICK_W'(1);
                  end
               end
`endif
               S_STOP: begin
                  if (tick_cnt == TICK_LAST) begin
                     tick_cnt <= '0;
                     if (rxs) begin
                        state <= S_IDLE;
                     end else begin
                        FRAME_ERR <= 1'b1;
                        state     <= S_BREAK;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + TICK_W'(1);
                  end
               end
               S_BREAK: begin
                  if (rxs) state <= S_IDLE;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

   always_comb begin
      word_done = BCLK && (state == S_STOP) && (tick_cnt == TICK_LAST) && rxs;
`ifdef UART_RX_PARITY_EN
      if (par_bad) word_done = 1'b0;
`endif
   end

   // Handshake: a word is transferred on every CLK edge where VALID and READY are both high.
   // VALID stays high with DATA stable until then; a word finishing while the held one is not
   // being taken is dropped and flagged with OVERRUN.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         DATA    <= '0;
         VALID   <= 1'b0;
         OVERRUN <= 1'b0;
      end else begin
         OVERRUN <= 1'b0;
         if (word_done) begin
            if (!VALID || READY) begin
               DATA  <= shreg;
               VALID <= 1'b1;
            end else begin
               OVERRUN <= 1'b1;
            end
         end else if (VALID && READY) begin
            VALID <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: serial frames driven bit by bit; received words and error pulses
// are compared against a frame-level model (expected word queue plus pulse counters).
`timescale 1ns/1ps

module tb_uart_rx;

   localparam int DIV      = 4;
   localparam int OS       = 16;
   localparam int BIT_CLKS = DIV * OS;
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_BREAK = 3'd4;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       bclk  = 1'b0;
   logic       rx    = 1'b1;
   logic       ready = 1'b0;
   logic [7:0] data;
   logic       valid;
   logic       frame_err;
   logic       overrun;
   logic [2:0] state_dbg;
`ifdef UART_RX_PARITY_EN
   logic       par_err;
`endif

   logic [7:0] exp_q[$];
   int n_checks = 0;
   int n_pass   = 0;
   int fe_cnt   = 0;
   int ovr_cnt  = 0;
   int par_cnt  = 0;
   int acc_cnt  = 0;
   int valid_cyc = 0;
   int exp_fe   = 0;
   int exp_ovr  = 0;
   int exp_par  = 0;
   int ready_mode = 2;   // 0: random, 1: held low, 2: held high
   int div_cnt  = 0;

   uart_rx #(.DATA_BITS(8), .OVERSAMPLE(OS)) dut (
      .CLK       (clk),
      .RST_N     (rst_n),
      .BCLK      (bclk),
      .RX        (rx),
      .READY     (ready),
      .DATA      (data),
      .VALID     (valid),
      .FRAME_ERR (frame_err),
      .OVERRUN   (overrun),
`ifdef UART_RX_PARITY_EN
      .PAR_ERR   (par_err),
`endif
      .STATE_DBG (state_dbg)
   );

   // Clock and baud tick: a short divider keeps frames a few hundred cycles long.
   always #10 clk = ~clk;

   always @(posedge clk) begin
      if (div_cnt == DIV - 1) begin
         div_cnt <= 0;
         bclk    <= 1'b1;
      end else begin
         div_cnt <= div_cnt + 1;
         bclk    <= 1'b0;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   // Consumer and pulse monitor; READY is updated first so the sampled pair is what the next edge sees.
   always @(negedge clk) begin
      case (ready_mode)
         0:       ready = ($urandom_range(0, 1) == 1);
         1:       ready = 1'b0;
         default: ready = 1'b1;
      endcase
      if (rst_n) begin
         fe_cnt  += int'(frame_err);
         ovr_cnt += int'(overrun);
`ifdef UART_RX_PARITY_EN
         par_cnt += int'(par_err);
`endif
         if (valid) valid_cyc++;
         if (valid && ready) begin
            acc_cnt++;
            check("accept_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) check("accept_data", data, exp_q.pop_front());
         end
      end
   end

   // Frame-level model: what one serial frame should produce.
   task automatic model_frame(input logic [7:0] w, input logic stop_b, input logic pf);
      if (pf) exp_par++;
      if (!stop_b) exp_fe++;
      else if (!pf) exp_q.push_back(w);
   endtask

   task automatic drive_bit(input logic b);
      rx = b;
      repeat (BIT_CLKS) @(negedge clk);
   endtask

   task automatic idle_bits(input int n);
      rx = 1'b1;
      repeat (n * BIT_CLKS) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] w, input logic stop_b, input logic pf);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(w[i]);
`ifdef UART_RX_PARITY_EN
      drive_bit((^w) ^ pf);
`endif
      drive_bit(stop_b);
   endtask

   task automatic wait_drain(input string tag);
      for (int i = 0; i < 4000 && exp_q.size() != 0; i++) @(negedge clk);
      check(tag, exp_q.size(), 0);
   endtask

   initial begin
      #(20 * 200000);
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int v0;
      int a0;
      int f0;
      logic [7:0] w;
      logic       sb;
      logic       pf;

      rst_n = 1'b0;
      rx    = 1'b1;
      repeat (5) @(negedge clk);
      check("reset_data", data, 8'h00);
      check("reset_valid", valid, 1'b0);
      check("reset_frame_err", frame_err, 1'b0);
      check("reset_overrun", overrun, 1'b0);
      check("reset_state", state_dbg, ST_IDLE);
      rst_n = 1'b1;
      idle_bits(2);

      // Clean 8N1 word with the consumer always ready.
      ready_mode = 2;
      v0 = valid_cyc;
      a0 = acc_cnt;
      model_frame(8'hA5, 1'b1, 1'b0);
      send_frame(8'hA5, 1'b1, 1'b0);
      idle_bits(1);
      check("a5_valid_cycles", valid_cyc - v0, 1);
      check("a5_accepts", acc_cnt - a0, 1);
      check("a5_frame_err", fe_cnt, exp_fe);

      // Glitch shorter than half a bit is a false start.
      v0 = valid_cyc;
      rx = 1'b0;
      repeat (4 * DIV) @(negedge clk);
      idle_bits(2);
      check("false_start_state", state_dbg, ST_IDLE);
      check("false_start_valid", valid_cyc - v0, 0);
      check("false_start_frame_err", fe_cnt, exp_fe);

      // Low stop bit followed by a long break.
      v0 = valid_cyc;
      model_frame(8'h3C, 1'b0, 1'b0);
      send_frame(8'h3C, 1'b0, 1'b0);
      repeat (20 * BIT_CLKS) @(negedge clk);
      check("break_state", state_dbg, ST_BREAK);
      check("break_frame_err", fe_cnt, exp_fe);
      check("break_valid", valid_cyc - v0, 0);
      idle_bits(2);
      check("break_release_state", state_dbg, ST_IDLE);

      // Two words with no consumer: the second is dropped while the first is held.
      ready_mode = 1;
      model_frame(8'h11, 1'b1, 1'b0);
      send_frame(8'h11, 1'b1, 1'b0);
      exp_ovr++;
      send_frame(8'h22, 1'b1, 1'b0);
      idle_bits(1);
      check("ovr_data", data, 8'h11);
      check("ovr_valid", valid, 1'b1);
      check("ovr_pulses", ovr_cnt, exp_ovr);
      ready_mode = 0;
      wait_drain("ovr_drain");

      // Reset in the middle of data bit 4 abandons the frame.
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(w[0] ^ w[0] ^ (i % 2 == 0));
      rx = 1'b1;
      repeat (BIT_CLKS / 2) @(negedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("midreset_data", data, 8'h00);
      check("midreset_state", state_dbg, ST_IDLE);
      check("midreset_valid", valid, 1'b0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      idle_bits(2);
      a0 = acc_cnt;
      model_frame(8'h96, 1'b1, 1'b0);
      send_frame(8'h96, 1'b1, 1'b0);
      idle_bits(1);
      wait_drain("midreset_drain");
      check("midreset_accepts", acc_cnt - a0, 1);

`ifdef UART_RX_PARITY_EN
      // Wrong then correct parity for 0x07.
      ready_mode = 2;
      v0 = valid_cyc;
      model_frame(8'h07, 1'b1, 1'b1);
      send_frame(8'h07, 1'b1, 1'b1);
      idle_bits(1);
      check("par_bad_pulses", par_cnt, exp_par);
      check("par_bad_valid", valid_cyc - v0, 0);
      model_frame(8'h07, 1'b1, 1'b0);
      send_frame(8'h07, 1'b1, 1'b0);
      idle_bits(1);
      wait_drain("par_good_drain");
`endif

      // Random words, occasional bad stop bits, random consumer and gaps.
      ready_mode = 0;
      for (int n = 0; n < 24; n++) begin
         w  = 8'($urandom());
         sb = ($urandom_range(0, 5) != 0);
`ifdef UART_RX_PARITY_EN
         pf = ($urandom_range(0, 4) == 0);
`else
         pf = 1'b0;
`endif
         model_frame(w, sb, pf);
         send_frame(w, sb, pf);
         idle_bits(sb ? $urandom_range(0, 2) : $urandom_range(1, 2));
      end
      idle_bits(1);
      wait_drain("final_drain");
      check("final_frame_err", fe_cnt, exp_fe);
      check("final_overrun", ovr_cnt, exp_ovr);
`ifdef UART_RX_PARITY_EN
      check("final_par_err", par_cnt, exp_par);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
